// File: rtl/mem_arbiter.sv
// Round-robin read-port arbiter between instruction fetch and load/store for the unified MEM block.
// Stores bypass arbitration. A store and an IF read to the same address in one cycle forward the store data.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    input  logic              if_flush,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen
);
    typedef enum logic {SRC_IF = 1'b0, SRC_LS = 1'b1} src_t;

    typedef struct packed {
        logic              valid;
        src_t              id;
        logic              fwd;
        logic [DATA_W-1:0] fwd_data;
    } pend_t;

    src_t              prio;
    pend_t             pend;
    logic              ls_load;
    logic              ls_store;
    logic              gnt_if_rd;
    logic              gnt_ls_rd;
    logic              rd_gnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] raddr_q;
    logic [DATA_W-1:0] resp_data;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;

    assign ls_load  = ls_req & ~ls_we;
    assign ls_store = ls_req & ls_we & ~rst;

    // prio only matters when both sides want the read port
    always_comb begin
        gnt_if_rd = 1'b0;
        gnt_ls_rd = 1'b0;
        if (!rst) begin
            if (if_req && ls_load) begin
                gnt_if_rd = (prio == SRC_IF);
                gnt_ls_rd = (prio == SRC_LS);
            end else begin
                gnt_if_rd = if_req;
                gnt_ls_rd = ls_load;
            end
        end
    end

    assign rd_gnt    = gnt_if_rd | gnt_ls_rd;
    assign rd_addr   = gnt_ls_rd ? ls_addr : if_addr;
    assign if_gnt    = gnt_if_rd;
    assign ls_gnt    = gnt_ls_rd | ls_store;
    assign mem_wen   = ls_store;
    assign mem_waddr = ls_addr;
    assign mem_wdata = ls_wdata;
    assign mem_raddr = rd_gnt ? rd_addr : raddr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio       <= SRC_IF;
            pend       <= '0;
            raddr_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (gnt_if_rd) begin
                prio <= SRC_LS;
            end else if (gnt_ls_rd) begin
                prio <= SRC_IF;
            end
            raddr_q       <= mem_raddr;
            pend.valid    <= rd_gnt;
            pend.id       <= gnt_ls_rd ? SRC_LS : SRC_IF;
            // MEM returns the pre-store value on a same-edge collision, so remember the store data
            pend.fwd      <= rd_gnt & ls_store & (ls_addr == rd_addr);
            pend.fwd_data <= ls_wdata;
            if_rdata_q    <= if_rdata;
            ls_rdata_q    <= ls_rdata;
        end
    end

    assign resp_data = pend.fwd ? pend.fwd_data : mem_rdata;
    assign if_rvalid = pend.valid & (pend.id == SRC_IF) & ~if_flush;
    assign ls_rvalid = pend.valid & (pend.id == SRC_LS);
    assign if_rdata  = if_rvalid ? resp_data : if_rdata_q;
    assign ls_rdata  = ls_rvalid ? resp_data : ls_rdata_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the processor's unified MEM block, which has one synchronous read port and one write port. The instruction-fetch (IF) unit and the load/store unit (LS) share the read port under round-robin arbitration. LS stores go straight to the write port. Read data comes back one cycle after grant and is steered to the winning requester, with same-cycle write-to-read forwarding and an IF flush that discards an in-flight fetch.

## Interface
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  IF read request; held until granted
- if_addr  in  ADDR_W  IF read address
- if_gnt  out  1  IF request accepted this cycle (combinational)
- if_flush  in  1  drop any IF response due this cycle
- if_rvalid  out  1  IF read data valid
- if_rdata  out  DATA_W  IF read data
- ls_req  in  1  LS request; held until granted
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  LS address
- ls_wdata  in  DATA_W  LS store data
- ls_gnt  out  1  LS request accepted this cycle (combinational)
- ls_rvalid  out  1  LS load data valid
- ls_rdata  out  DATA_W  LS load data
- mem_raddr  out  ADDR_W  to MEM read address
- mem_rdata  in  DATA_W  from MEM; valid the cycle after mem_raddr is sampled
- mem_waddr  out  ADDR_W  to MEM write address
- mem_wdata  out  DATA_W  to MEM write data
- mem_wen  out  1  to MEM write enable

## Operation
- Reads contend for the read port; at most one read is granted per cycle.
- Stores never contend:
  - ls_req & ls_we gives ls_gnt = 1 in the same cycle.
  - mem_wen = 1, mem_waddr = ls_addr, mem_wdata = ls_wdata, all combinational.
- Read contention exists only when if_req = 1 and (ls_req & ~ls_we) = 1.
  - Winner is the requester named by the prio register (0 = IF, 1 = LS).
  - The loser sees gnt = 0 and keeps its request asserted.
- Single read requester: granted immediately, regardless of prio.
- prio update:
  - After any granted read, prio <= the non-granted side (IF grant gives prio = 1, LS grant gives prio = 0).
  - prio is unchanged in cycles with no read grant.
- mem_raddr = the granted read address. With no read grant it holds its last value; the value is don't-care.
- Response tracking register pend = {valid, id, fwd, fwd_data}, loaded on every edge:
  - valid = read granted
  - id = granted requester
  - fwd = store granted this cycle & mem_wen & (ls_addr == granted read address)
  - fwd_data = ls_wdata
- Forwarding only happens with an IF read, since LS cannot issue a load and a store in the same cycle.
- Response cycle (pend.valid = 1):
  - Data = fwd ? fwd_data : mem_rdata.
  - It drives if_rdata/if_rvalid when id = IF, otherwise ls_rdata/ls_rvalid.
- Flush: if pend.id = IF and if_flush = 1, if_rvalid = 0 that cycle and the fetch data is lost.
  - if_flush never affects LS responses.
  - A new IF request in the flush cycle is still arbitrated normally.
- No response backpressure: requesters must accept rvalid data in the cycle it is asserted.
- rdata outputs hold their last value when rvalid = 0.

## Timing
- Read latency: grant in cycle N gives rvalid in cycle N+1. Back-to-back grants give one response per cycle.
- A store granted in cycle N is written at edge N→N+1; a read granted in N+1 or later sees the new data.
- A store and an IF read to the same address in the same cycle N: the IF response in N+1 carries ls_wdata (forwarded).
- Reset (asynchronous, any time):
  - prio = 0, pend.valid = 0, pend.fwd = 0.
  - if_rvalid = ls_rvalid = 0, if_rdata = ls_rdata = 0.
  - if_gnt and ls_gnt are forced 0 while rst = 1.
  - mem_wen = 0 while rst = 1.
- Reset asserted in cycle N+1 after a grant in N: the response is discarded and no rvalid follows after release.
- First cycle after reset release: a contended read goes to IF.

## Test plan
- IF-only reads to 0x10, 0x14, 0x18 in consecutive cycles, MEM preloaded 0xA0/0xA4/0xA8 → if_gnt = 1 each cycle; if_rvalid in the following cycles with 0xA0, 0xA4, 0xA8; ls_rvalid = 0 throughout.
- IF and LS loads both held for 4 cycles after reset → grants alternate IF, LS, IF, LS; each response appears one cycle after its grant, on the correct port.
- LS store 0xDEADBEEF to 0x40 with a simultaneous IF read of 0x40 (MEM held 0x0) → ls_gnt = 1 and if_gnt = 1; next cycle if_rdata = 0xDEADBEEF. A repeat IF read of 0x40 two cycles later returns 0xDEADBEEF from MEM.
- IF read granted in N, if_flush = 1 in N+1 → if_rvalid = 0 in N+1. A second IF read granted in N+1 returns valid data in N+2.
- LS store every cycle while IF reads continuously → both granted every cycle; mem_wen = 1 each cycle; no IF stalls.
- rst pulsed for half a cycle between a grant and its response → outputs drop to 0 immediately; no rvalid after release; the next contended read goes to IF.
